// File: rtl/cacheline_arb_pkg.sv
// Shared definitions for the I/D cacheline arbiter.
//   arb_state_e : arbiter FSM states
//   grant_e     : which requester won arbitration
//   offset_w()  : number of byte-offset bits inside one cache line
// Optional feature macro: CACHELINE_ARB_RR_EN (round-robin arbitration).
package cacheline_arb_pkg;

   localparam int ADDR_W_DEF = 32;
   localparam int LINE_W_DEF = 256;

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      BUSY_I = 3'd1,
      BUSY_D = 3'd2,
      RESP_I = 3'd3,
      RESP_D = 3'd4
   } arb_state_e;

   typedef enum logic {
      GRANT_I = 1'b0,
      GRANT_D = 1'b1
   } grant_e;

   // Byte-offset bits of a line of line_w bits (5 for a 256-bit line).
   function automatic int offset_w(input int line_w);
      return $clog2(line_w / 8);
   endfunction

   localparam int OFFSET_W = offset_w(LINE_W_DEF);

endpackage

// File: rtl/cacheline_arb_pick.sv
// Combinational grant selection between the I-cache and D-cache requests.
// Ports:
//   i_req_i      : I-cache has a pending request
//   d_req_i      : D-cache has a pending request (read or write)
//   last_grant_i : previous winner (only with CACHELINE_ARB_RR_EN)
//   valid_o      : at least one request pending
//   grant_o      : selected requester (meaningful only with valid_o)
// Macro CACHELINE_ARB_RR_EN: when defined, simultaneous requests alternate;
// otherwise the D-cache always wins.
module cacheline_arb_pick
   import cacheline_arb_pkg::*;
(
   input  logic   i_req_i,
   input  logic   d_req_i,
`ifdef CACHELINE_ARB_RR_EN
   input  grant_e last_grant_i,
`endif
   output logic   valid_o,
   output grant_e grant_o
);

   // Pick a winner; only a true conflict consults the arbitration policy.
   always_comb begin
      valid_o = i_req_i | d_req_i;
      grant_o = GRANT_I;
      if (i_req_i && d_req_i) begin
`ifdef CACHELINE_ARB_RR_EN
         if (last_grant_i == GRANT_D) begin
            grant_o = GRANT_I;
         end else begin
            grant_o = GRANT_D;
         end
`else
         grant_o = GRANT_D;
`endif
      end else if (d_req_i) begin
         grant_o = GRANT_D;
      end else begin
         grant_o = GRANT_I;
      end
   end

endmodule

// File: rtl/cacheline_arbiter.sv
// Two-to-one arbiter merging I-cache (read-only) and D-cache (read/write)
// line requests onto the single LLC-side port of the cacheline adaptor.
// One transaction is outstanding at a time; each requester holds its request
// until it sees its one-cycle resp pulse.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   i_addr, i_read               : I-cache request
//   i_rdata, i_resp              : I-cache completion (line valid with resp)
//   d_addr, d_read, d_write      : D-cache request (write wins if both set)
//   d_wdata                      : D-cache writeback line
//   d_rdata, d_resp              : D-cache completion (line valid with resp)
//   mem_addr/read/write/wdata    : registered request to the adaptor
//   mem_rdata, mem_resp          : adaptor completion
// Macro CACHELINE_ARB_RR_EN: round-robin on simultaneous requests;
// undefined gives fixed D-cache priority.
module cacheline_arbiter
   import cacheline_arb_pkg::*;
#(
   parameter int ADDR_W = ADDR_W_DEF,
   parameter int LINE_W = LINE_W_DEF
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [ADDR_W-1:0] i_addr,
   input  logic              i_read,
   output logic [LINE_W-1:0] i_rdata,
   output logic              i_resp,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic              d_read,
   input  logic              d_write,
   input  logic [LINE_W-1:0] d_wdata,
   output logic [LINE_W-1:0] d_rdata,
   output logic              d_resp,
   output logic [ADDR_W-1:0] mem_addr,
   output logic              mem_read,
   output logic              mem_write,
   output logic [LINE_W-1:0] mem_wdata,
   input  logic [LINE_W-1:0] mem_rdata,
   input  logic              mem_resp
);

   localparam int OFF_W = offset_w(LINE_W);
   // Byte-offset bits inside a line; cleared on the way to the adaptor.
   localparam logic [ADDR_W-1:0] OFF_MASK = ADDR_W'((64'd1 << OFF_W) - 64'd1);

   arb_state_e        state_q,     state_d;
   logic [ADDR_W-1:0] mem_addr_q,  mem_addr_d;
   logic              mem_read_q,  mem_read_d;
   logic              mem_write_q, mem_write_d;
   logic [LINE_W-1:0] mem_wdata_q, mem_wdata_d;
   logic [LINE_W-1:0] rdata_q,     rdata_d;
   logic              i_resp_q,    i_resp_d;
   logic              d_resp_q,    d_resp_d;

   logic              grant_valid_s;
   grant_e            grant_s;

`ifdef CACHELINE_ARB_RR_EN
   grant_e            last_grant_q, last_grant_d;
`endif

   cacheline_arb_pick u_pick (
      .i_req_i      (i_read),
      .d_req_i      (d_read | d_write),
`ifdef CACHELINE_ARB_RR_EN
      .last_grant_i (last_grant_q),
`endif
      .valid_o      (grant_valid_s),
      .grant_o      (grant_s)
   );

   // Next-state logic: arbitrate in IDLE, hold the adaptor request in BUSY,
   // pulse the completion in RESP.
   always_comb begin
      state_d     = state_q;
      mem_addr_d  = mem_addr_q;
      mem_read_d  = mem_read_q;
      mem_write_d = mem_write_q;
      mem_wdata_d = mem_wdata_q;
      rdata_d     = rdata_q;
      i_resp_d    = 1'b0;
      d_resp_d    = 1'b0;
`ifdef CACHELINE_ARB_RR_EN
      last_grant_d = last_grant_q;
`endif
      case (state_q)
         IDLE: begin
            if (grant_valid_s && (grant_s == GRANT_D)) begin
               state_d     = BUSY_D;
               mem_addr_d  = d_addr & ~OFF_MASK;
               // A simultaneous read+write is served as the writeback only.
               mem_write_d = d_write;
               mem_read_d  = ~d_write;
               mem_wdata_d = d_write ? d_wdata : {LINE_W{1'b0}};
`ifdef CACHELINE_ARB_RR_EN
               last_grant_d = GRANT_D;
`endif
            end else if (grant_valid_s) begin
               state_d     = BUSY_I;
               mem_addr_d  = i_addr & ~OFF_MASK;
               mem_write_d = 1'b0;
               mem_read_d  = 1'b1;
               mem_wdata_d = {LINE_W{1'b0}};
`ifdef CACHELINE_ARB_RR_EN
               last_grant_d = GRANT_I;
`endif
            end else begin
               state_d = IDLE;
            end
         end
         BUSY_I, BUSY_D: begin
            if (mem_resp) begin
               // Drop the adaptor request right away so it cannot restart.
               state_d     = (state_q == BUSY_D) ? RESP_D : RESP_I;
               rdata_d     = mem_rdata;
               mem_addr_d  = {ADDR_W{1'b0}};
               mem_read_d  = 1'b0;
               mem_write_d = 1'b0;
               mem_wdata_d = {LINE_W{1'b0}};
               i_resp_d    = (state_q == BUSY_I);
               d_resp_d    = (state_q == BUSY_D);
            end else begin
               state_d = state_q;
            end
         end
         RESP_I, RESP_D: begin
            // Requests are not sampled here; the requester is still
            // seeing its resp and will drop its request.
            state_d = IDLE;
         end
         default: begin
            state_d     = IDLE;
            mem_addr_d  = {ADDR_W{1'b0}};
            mem_read_d  = 1'b0;
            mem_write_d = 1'b0;
            mem_wdata_d = {LINE_W{1'b0}};
         end
      endcase
   end

   // State and output registers with synchronous reset.
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= IDLE;
         mem_addr_q  <= {ADDR_W{1'b0}};
         mem_read_q  <= 1'b0;
         mem_write_q <= 1'b0;
         mem_wdata_q <= {LINE_W{1'b0}};
         rdata_q     <= {LINE_W{1'b0}};
         i_resp_q    <= 1'b0;
         d_resp_q    <= 1'b0;
`ifdef CACHELINE_ARB_RR_EN
         last_grant_q <= GRANT_I;
`endif
      end else begin
         state_q     <= state_d;
         mem_addr_q  <= mem_addr_d;
         mem_read_q  <= mem_read_d;
         mem_write_q <= mem_write_d;
         mem_wdata_q <= mem_wdata_d;
         rdata_q     <= rdata_d;
         i_resp_q    <= i_resp_d;
         d_resp_q    <= d_resp_d;
`ifdef CACHELINE_ARB_RR_EN
         last_grant_q <= last_grant_d;
`endif
      end
   end

   assign mem_addr  = mem_addr_q;
   assign mem_read  = mem_read_q;
   assign mem_write = mem_write_q;
   assign mem_wdata = mem_wdata_q;
   assign i_rdata   = rdata_q;
   assign d_rdata   = rdata_q;
   assign i_resp    = i_resp_q;
   assign d_resp    = d_resp_q;

endmodule

// File: tb/tb_cacheline_arbiter.sv
module tb_cacheline_arbiter;

   logic         clk = 1'b0;
   logic         rst;
   logic [31:0]  i_addr, d_addr, mem_addr;
   logic         i_read, i_resp, d_read, d_write, d_resp;
   logic [255:0] i_rdata, d_rdata, d_wdata, mem_wdata, mem_rdata;
   logic         mem_read, mem_write, mem_resp;

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   cacheline_arbiter dut (
      .clk(clk), .rst(rst),
      .i_addr(i_addr), .i_read(i_read), .i_rdata(i_rdata), .i_resp(i_resp),
      .d_addr(d_addr), .d_read(d_read), .d_write(d_write), .d_wdata(d_wdata),
      .d_rdata(d_rdata), .d_resp(d_resp),
      .mem_addr(mem_addr), .mem_read(mem_read), .mem_write(mem_write),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .mem_resp(mem_resp)
   );

   typedef struct {
      logic         is_d;
      logic         rd;
      logic         wr;
      logic [31:0]  addr;
      logic [255:0] wdata;
      logic [255:0] rdata;
      int           lat;
      logic [31:0]  exp_addr;
      logic         exp_wr;
   } vec_t;

   vec_t vecs[5];

   task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   task automatic do_reset();
      rst = 1'b1;
      repeat (2) @(negedge clk);
      rst = 1'b0;
   endtask

   // Waits for the adaptor request, checks it, stalls lat cycles, completes it
   // and checks the resp pulse; the requester then drops its request.
   task automatic run_txn(input string nm, input logic is_d, input logic [31:0] exp_addr,
                          input logic exp_wr, input logic [255:0] exp_wdata, input int lat,
                          input logic [255:0] rdata, input int max_wait);
      int n;
      n = 0;
      @(negedge clk);
      while (!(mem_read || mem_write) && n < max_wait) begin
         @(negedge clk);
         n++;
      end
      if (!(mem_read || mem_write)) begin
         checks++;
         errors++;
         $display("FAIL %s_start: no mem request after %0d cycles", nm, max_wait + 1);
         i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
         return;
      end
      chk({nm, "_addr"},  {224'd0, mem_addr}, {224'd0, exp_addr});
      chk({nm, "_read"},  {255'd0, mem_read}, {255'd0, ~exp_wr});
      chk({nm, "_write"}, {255'd0, mem_write}, {255'd0, exp_wr});
      chk({nm, "_wdata"}, mem_wdata, exp_wr ? exp_wdata : 256'd0);
      for (int k = 0; k < lat; k++) begin
         @(negedge clk);
         chk({nm, "_hold_rw"}, {254'd0, mem_read, mem_write}, {254'd0, ~exp_wr, exp_wr});
         chk({nm, "_hold_resp"}, {254'd0, i_resp, d_resp}, 256'd0);
      end
      mem_resp = 1'b1;
      mem_rdata = rdata;
      @(negedge clk);
      mem_resp = 1'b0;
      mem_rdata = 256'd0;
      chk({nm, "_drop_rw"}, {254'd0, mem_read, mem_write}, 256'd0);
      chk({nm, "_resp"}, {254'd0, i_resp, d_resp}, {254'd0, ~is_d, is_d});
      chk({nm, "_rdata"}, is_d ? d_rdata : i_rdata, rdata);
      if (is_d) begin
         d_read = 1'b0;
         d_write = 1'b0;
      end else begin
         i_read = 1'b0;
      end
      @(negedge clk);
      chk({nm, "_resp_end"}, {254'd0, i_resp, d_resp}, 256'd0);
   endtask

   initial begin
      logic first_d;
      logic [31:0] hold_addr;

      vecs[0] = '{1'b0, 1'b1, 1'b0, 32'h0000_1234, 256'd0, {32{8'hA5}}, 4, 32'h0000_1220, 1'b0};
      vecs[1] = '{1'b1, 1'b0, 1'b1, 32'h8000_0040, {8{32'h1122_3344}}, {8{32'h0BAD_F00D}}, 2, 32'h8000_0040, 1'b1};
      vecs[2] = '{1'b1, 1'b1, 1'b0, 32'h0000_FFFF, 256'd0, {8{32'hDEAD_BEEF}}, 0, 32'h0000_FFE0, 1'b0};
      vecs[3] = '{1'b1, 1'b1, 1'b1, 32'h1234_5678, {32{8'h3C}}, {8{32'h7777_0000}}, 1, 32'h1234_5660, 1'b1};
      vecs[4] = '{1'b0, 1'b1, 1'b0, 32'hFFFF_FFFF, 256'd0, {16{16'h5AA5}}, 3, 32'hFFFF_FFE0, 1'b0};

      i_addr = 32'd0; d_addr = 32'd0; i_read = 1'b0; d_read = 1'b0; d_write = 1'b0;
      d_wdata = 256'd0; mem_rdata = 256'd0; mem_resp = 1'b0; rst = 1'b1;
      @(negedge clk);
      do_reset();
      @(negedge clk);
      chk("reset_mem", {222'd0, mem_read, mem_write, mem_addr}, 256'd0);
      chk("reset_wdata", mem_wdata, 256'd0);
      chk("reset_resp", {254'd0, i_resp, d_resp}, 256'd0);
      chk("reset_rdata", i_rdata | d_rdata, 256'd0);

      // Single transactions from the vector table.
      for (int v = 0; v < 5; v++) begin
         if (vecs[v].is_d) begin
            d_addr = vecs[v].addr; d_read = vecs[v].rd; d_write = vecs[v].wr;
            d_wdata = vecs[v].wdata; i_addr = 32'h5555_5555;
         end else begin
            i_addr = vecs[v].addr; i_read = vecs[v].rd;
            d_addr = 32'hAAAA_AAAA; d_wdata = {8{32'hFFFF_0000}};
         end
         run_txn($sformatf("vec%0d", v), vecs[v].is_d, vecs[v].exp_addr, vecs[v].exp_wr,
                 vecs[v].wdata, vecs[v].lat, vecs[v].rdata, 0);
      end

      // Three back-to-back simultaneous pairs: D, I, D, I, D, I.
      do_reset();
      for (int p = 0; p < 3; p++) begin
         i_addr = 32'h0000_0100 + 32'(p * 64); i_read = 1'b1;
         d_addr = 32'h0000_2000 + 32'(p * 64); d_read = 1'b1;
         run_txn($sformatf("pair%0d_d", p), 1'b1, 32'h0000_2000 + 32'(p * 64), 1'b0,
                 256'd0, 1, {8{32'hD000_0000 + 32'(p)}}, 0);
         run_txn($sformatf("pair%0d_i", p), 1'b0, 32'h0000_0100 + 32'(p * 64), 1'b0,
                 256'd0, 1, {8{32'h1000_0000 + 32'(p)}}, 0);
      end

      // After a lone D grant, a conflict goes to I only under round-robin.
      d_addr = 32'h0000_3000; d_read = 1'b1;
      run_txn("lone_d", 1'b1, 32'h0000_3000, 1'b0, 256'd0, 0, {8{32'h3333_3333}}, 0);
`ifdef CACHELINE_ARB_RR_EN
      first_d = 1'b0;
`else
      first_d = 1'b1;
`endif
      i_addr = 32'h0000_4000; i_read = 1'b1;
      d_addr = 32'h0000_5000; d_write = 1'b1; d_wdata = {8{32'h5050_5050}};
      if (first_d) begin
         run_txn("pol_first_d", 1'b1, 32'h0000_5000, 1'b1, {8{32'h5050_5050}}, 1, {8{32'h1}}, 0);
         run_txn("pol_second_i", 1'b0, 32'h0000_4000, 1'b0, 256'd0, 1, {8{32'h2}}, 0);
      end else begin
         run_txn("pol_first_i", 1'b0, 32'h0000_4000, 1'b0, 256'd0, 1, {8{32'h2}}, 0);
         run_txn("pol_second_d", 1'b1, 32'h0000_5000, 1'b1, {8{32'h5050_5050}}, 1, {8{32'h1}}, 0);
      end

      // Reset while BUSY_D aborts without a resp.
      d_addr = 32'h0000_6000; d_read = 1'b1;
      @(negedge clk);
      chk("abort_busy", {255'd0, mem_read}, 256'd1);
      rst = 1'b1;
      mem_resp = 1'b1;
      mem_rdata = {8{32'hEEEE_EEEE}};
      @(negedge clk);
      rst = 1'b0;
      mem_resp = 1'b0;
      mem_rdata = 256'd0;
      d_read = 1'b0;
      chk("abort_rw", {254'd0, mem_read, mem_write}, 256'd0);
      for (int k = 0; k < 5; k++) begin
         @(negedge clk);
         chk("abort_no_resp", {254'd0, i_resp, d_resp}, 256'd0);
      end
      // Back in IDLE: a fresh request gets the one-cycle latency.
      i_addr = 32'h0000_7000; i_read = 1'b1;
      run_txn("after_abort", 1'b0, 32'h0000_7000, 1'b0, 256'd0, 0, {8{32'h7070_7070}}, 0);

      // 100-cycle adaptor stall: request held steady, no resp.
      i_addr = 32'h0000_803F; i_read = 1'b1;
      @(negedge clk);
      hold_addr = 32'h0000_8020;
      for (int k = 0; k < 100; k++) begin
         chk("stall_read", {255'd0, mem_read}, 256'd1);
         chk("stall_addr", {224'd0, mem_addr}, {224'd0, hold_addr});
         chk("stall_resp", {254'd0, i_resp, d_resp}, 256'd0);
         @(negedge clk);
      end
      mem_resp = 1'b1;
      mem_rdata = {8{32'h8888_8888}};
      @(negedge clk);
      mem_resp = 1'b0;
      mem_rdata = 256'd0;
      chk("stall_done_resp", {255'd0, i_resp}, 256'd1);
      chk("stall_done_rdata", i_rdata, {8{32'h8888_8888}});
      i_read = 1'b0;
      @(negedge clk);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
